vending_machine_mc: RTL
=======================

# vending_machine_mc

Parametrised multi-product vending controller: the next generation of the two-product `vending_machine`. It accumulates credit from a 3-denomination coin acceptor and keeps a per-slot stock count for `N_GOODS` products with individual prices. It vends on a validated selection and pays change or refunds one coin per cycle. It sits between the coin acceptor and the dispenser/coin-hopper drivers.

## Interface
- `N_GOODS`, 4: number of product slots (≥2).
- `CREDIT_W`, 7: credit register width.
- `STOCK_W`, 4: per-slot stock counter width.
- `MAX_CREDIT`, 99: credit ceiling; must be < 2^CREDIT_W.
- `PRICE`, {5,25,10,15}: packed N_GOODS×CREDIT_W price table, slot 0 in the LSBs (slot0=15, slot1=10, slot2=25, slot3=5). Each price must be >0 and ≤MAX_CREDIT.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `coin` in 2: 00 none, 01 = 1 unit, 10 = 5, 11 = 10; one coin per cycle.
- `sel_valid` in 1: selection strobe.
- `sel` in $clog2(N_GOODS): selected slot.
- `cancel` in 1: refund request.
- `restock_valid` in 1: restock strobe.
- `restock_slot` in $clog2(N_GOODS): slot to restock.
- `restock_qty` in STOCK_W: items added.
- `sell` out 1: one-cycle vend pulse.
- `sell_slot` out $clog2(N_GOODS): slot vended; valid with `sell`.
- `change` out 2: coin-hopper command, same encoding as `coin`; 00 = idle.
- `busy` out 1: high in VEND and CHANGE.
- `credit` out CREDIT_W: current credit.
- `coin_reject` out 1: one-cycle pulse; the presented coin was not accepted.
- `err` out 1: one-cycle pulse; selection refused.
- `sold_out` out N_GOODS: bit k set while stock[k]==0.

## Operation
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE.
- Priority in IDLE/CREDIT is cancel > sel_valid > coin. A coin presented in the same cycle as an accepted cancel or select is rejected.
- Coin: accepted if credit+value ≤ MAX_CREDIT; credit is incremented and the state becomes CREDIT. Otherwise `coin_reject` pulses and credit is unchanged.
- Coins presented in VEND or CHANGE are rejected.
- sel_valid with stock[sel]==0, credit<PRICE[sel], or sel≥N_GOODS: `err` pulses and state and credit are unchanged.
- sel_valid otherwise: go to VEND. In VEND: `sell`=1, `sell_slot`=sel, credit -= price, stock[sel] decrements. Next state is CHANGE if the remainder is >0, else IDLE.
- cancel with credit>0: go to CHANGE. With credit==0 it is ignored.
- CHANGE (greedy selection): each cycle emit the largest denomination ≤ credit (10, 5, then 1) and subtract it. When credit reaches 0, `change`=00 and the state becomes IDLE.
- `sel_valid` and `cancel` are ignored in VEND and CHANGE.
- Restock is accepted in any state: stock += qty, saturating at 2^STOCK_W−1.
- Restock of the slot being vended in the same cycle: net = stock−1+qty, saturated.
- Reset: state IDLE, credit 0, all stock 0, and every output 0 except `sold_out`, which is all-ones. Reset mid-VEND or mid-CHANGE abandons the remaining change without error.

## Timing
- All outputs are registered.
- Coin at edge t: `credit` is updated at t+1; `coin_reject` pulses at t+1.
- Valid select at t: `sell`/`sell_slot` at t+1 with the reduced `credit`. First `change` coin at t+2. `err` appears at t+1 on refusal.
- Cancel at t: first `change` coin at t+1. Change takes one coin per cycle, and `busy` falls in the cycle `change` returns to 00.
- `sold_out` reflects stock one cycle after the update.

## Structure
- `vending_pkg`:
  - coin encoding enum;
  - state enum;
  - denomination constants 1/5/10;
  - `coin_value()` function;
  - greedy `next_change()` function.
- Sub-module `vm_stock_bank`: N_GOODS saturating counters with decrement and restock ports and `sold_out` flags. The FSM, credit register and change sequencer stay in the top level.

## Test plan
- Reset, restock slot1 qty 3, coins 10 then 5 (credit 15), select slot1 → `sell`, `sell_slot`=1, credit 5, one `change`=10, then IDLE, stock1=2.
- Credit 10, select slot2 (price 25) → `err` pulse, credit remains 10, no `sell`.
- Select slot3 with stock 0 and credit 10 → `err`, `sold_out[3]`=1. Restock slot3 qty 2 → `sold_out[3]`=0.
- Coins 10, 5, 1, 1 (credit 17), cancel → `change` = 11, 10, 01, 01 on consecutive cycles, then 00, credit 0, `busy` low.
- Credit 95, coin 10 → `coin_reject`, credit stays 95. Coin 1 together with sel_valid → coin rejected and the select evaluated against the pre-coin credit.
- Assert `rst` asynchronously mid-CHANGE → `change`=00 and credit 0 immediately, and all stock cleared.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and helpers for the multi-product vending controller.
// Coin encoding, FSM states, denominations and greedy change selection.
package vending_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_1    = 2'b01,
        COIN_5    = 2'b10,
        COIN_10   = 2'b11
    } coin_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } state_e;

    localparam logic [3:0] DENOM_1  = 4'd1;
    localparam logic [3:0] DENOM_5  = 4'd5;
    localparam logic [3:0] DENOM_10 = 4'd10;

    // Face value of a coin code in credit units.
    function automatic logic [3:0] coin_value(input coin_e c);
        logic [3:0] v;
        v = 4'd0;
        unique case (c)
            COIN_NONE: v = 4'd0;
            COIN_1:    v = DENOM_1;
            COIN_5:    v = DENOM_5;
            COIN_10:   v = DENOM_10;
        endcase
        return v;
    endfunction

    // Largest denomination not exceeding the remaining credit.
    function automatic coin_e next_change(input logic [15:0] c);
        coin_e r;
        if (c >= 16'(DENOM_10)) begin
            r = COIN_10;
        end else if (c >= 16'(DENOM_5)) begin
            r = COIN_5;
        end else if (c >= 16'(DENOM_1)) begin
            r = COIN_1;
        end else begin
            r = COIN_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-slot saturating stock counters with vend decrement and restock.
// Sold-out flags are registered alongside the counters.
module vm_stock_bank
    import vending_pkg::*;
#(
    parameter int N_GOODS = 4,
    parameter int STOCK_W = 4,
    parameter int SEL_W   = $clog2(N_GOODS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_valid_i,
    input  logic [SEL_W-1:0]   dec_slot_i,
    input  logic               rs_valid_i,
    input  logic [SEL_W-1:0]   rs_slot_i,
    input  logic [STOCK_W-1:0] rs_qty_i,
    output logic [N_GOODS-1:0] sold_out_o
);

    logic [STOCK_W-1:0] stock_q [N_GOODS];
    logic [STOCK_W-1:0] stock_d [N_GOODS];
    logic [STOCK_W:0]   sum_w   [N_GOODS];
    logic [N_GOODS-1:0] sold_out_q;

    // Net update per slot: add restock, remove vended item, clamp at full.
    always_comb begin
        for (int k = 0; k < N_GOODS; k++) begin
            sum_w[k] = {1'b0, stock_q[k]};
            if (rs_valid_i && rs_slot_i == SEL_W'(k)) begin
                sum_w[k] = sum_w[k] + {1'b0, rs_qty_i};
            end
            if (dec_valid_i && dec_slot_i == SEL_W'(k) && sum_w[k] != '0) begin
                sum_w[k] = sum_w[k] - (STOCK_W+1)'(1);
            end
            stock_d[k] = sum_w[k][STOCK_W] ? '1 : sum_w[k][STOCK_W-1:0];
        end
    end

    // Counter and sold-out flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_GOODS; k++) begin
                stock_q[k] <= '0;
            end
            sold_out_q <= '1;
        end else begin
            for (int k = 0; k < N_GOODS; k++) begin
                stock_q[k]    <= stock_d[k];
                sold_out_q[k] <= (stock_d[k] == '0);
            end
        end
    end

    assign sold_out_o = sold_out_q;

endmodule

// File: rtl/vending_machine_mc.sv
// Multi-product vending controller: credit, selection, vend, change.
// Change is paid greedily, one hopper coin per cycle.
module vending_machine_mc
    import vending_pkg::*;
#(
    parameter int N_GOODS    = 4,
    parameter int CREDIT_W   = 7,
    parameter int STOCK_W    = 4,
    parameter int MAX_CREDIT = 99,
    parameter logic [N_GOODS*CREDIT_W-1:0] PRICE =
        {7'd5, 7'd25, 7'd10, 7'd15},
    parameter int SEL_W      = $clog2(N_GOODS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    input  logic                restock_valid,
    input  logic [SEL_W-1:0]    restock_slot,
    input  logic [STOCK_W-1:0]  restock_qty,
    output logic                sell,
    output logic [SEL_W-1:0]    sell_slot,
    output logic [1:0]          change,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                err,
    output logic [N_GOODS-1:0]  sold_out
);

    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                sell_q;
    logic [SEL_W-1:0]    sell_slot_q;
    coin_e               change_q;
    logic                busy_q;
    logic                coin_reject_q;
    logic                err_q;

    coin_e               coin_w;
    logic [CREDIT_W:0]   coin_sum_w;
    logic                coin_fit_w;
    logic                coin_in_w;
    logic [CREDIT_W-1:0] price_w;
    logic                sel_oob_w;
    logic                sel_ok_w;
    logic                cancel_take_w;
    logic                idle_like_w;
    logic                vend_take_w;
    coin_e               chg_coin_w;
    logic [CREDIT_W-1:0] chg_val_w;
    logic [N_GOODS-1:0]  sold_out_w;

    assign coin_w     = coin_e'(coin);
    assign coin_in_w  = (coin_w != COIN_NONE);
    assign coin_sum_w = {1'b0, credit_q}
                      + (CREDIT_W+1)'(coin_value(coin_w));
    assign coin_fit_w = (coin_sum_w <= (CREDIT_W+1)'(MAX_CREDIT));

    // Slot indices beyond the table only exist when N_GOODS is not 2^SEL_W.
    if (N_GOODS == (1 << SEL_W)) begin : g_sel_pow2
        assign sel_oob_w = 1'b0;
    end else begin : g_sel_npow2
        assign sel_oob_w = ({1'b0, sel} >= (SEL_W+1)'(N_GOODS));
    end

    assign price_w  = PRICE[sel*CREDIT_W +: CREDIT_W];
    assign sel_ok_w = !sel_oob_w
                   && !sold_out_w[sel]
                   && (credit_q >= price_w);

    assign idle_like_w   = (state_q == S_IDLE) || (state_q == S_CREDIT);
    assign cancel_take_w = cancel && (credit_q != '0);
    assign vend_take_w   = idle_like_w && !cancel_take_w
                        && sel_valid && sel_ok_w;

    assign chg_coin_w = next_change(16'(credit_q));
    assign chg_val_w  = CREDIT_W'(coin_value(chg_coin_w));

    vm_stock_bank #(
        .N_GOODS (N_GOODS),
        .STOCK_W (STOCK_W),
        .SEL_W   (SEL_W)
    ) u_stock (
        .clk         (clk),
        .rst         (rst),
        .dec_valid_i (vend_take_w),
        .dec_slot_i  (sel),
        .rs_valid_i  (restock_valid),
        .rs_slot_i   (restock_slot),
        .rs_qty_i    (restock_qty),
        .sold_out_o  (sold_out_w)
    );

    // Main FSM: credit intake, selection, vend and change payout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            sell_q        <= 1'b0;
            sell_slot_q   <= '0;
            change_q      <= COIN_NONE;
            busy_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            sell_q        <= 1'b0;
            err_q         <= 1'b0;
            coin_reject_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_CREDIT: begin
                    change_q <= COIN_NONE;
                    if (cancel_take_w) begin
                        change_q      <= chg_coin_w;
                        credit_q      <= credit_q - chg_val_w;
                        busy_q        <= 1'b1;
                        state_q       <= S_CHANGE;
                        coin_reject_q <= coin_in_w;
                    end else if (sel_valid) begin
                        coin_reject_q <= coin_in_w;
                        if (sel_ok_w) begin
                            credit_q    <= credit_q - price_w;
                            sell_q      <= 1'b1;
                            sell_slot_q <= sel;
                            busy_q      <= 1'b1;
                            state_q     <= S_VEND;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (coin_in_w) begin
                        if (coin_fit_w) begin
                            credit_q <= coin_sum_w[CREDIT_W-1:0];
                            state_q  <= S_CREDIT;
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end
                end
                S_VEND, S_CHANGE: begin
                    coin_reject_q <= coin_in_w;
                    if (credit_q == '0) begin
                        change_q <= COIN_NONE;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        change_q <= chg_coin_w;
                        credit_q <= credit_q - chg_val_w;
                        busy_q   <= 1'b1;
                        state_q  <= S_CHANGE;
                    end
                end
            endcase
        end
    end

    assign sell        = sell_q;
    assign sell_slot   = sell_slot_q;
    assign change      = change_q;
    assign busy        = busy_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign err         = err_q;
    assign sold_out    = sold_out_w;

endmodule
